// File: rtl/multiplicador_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : multiplicador_pkg
//  Brief    : State encodings, default width and magnitude helper for the
//             sequential shift-add multiplier.
//  Revision : 1.0 - initial release
// ============================================================================
package multiplicador_pkg;

  localparam int c_default_n = 8;
  // Working width of the magnitude helper; operands are zero-extended to it.
  localparam int c_mag_w     = 64;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    TEST  = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  function automatic logic [c_mag_w-1:0] magnitude(input logic [c_mag_w-1:0] v,
                                                   input logic               neg);
    return neg ? -v : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/multiplicador_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : multiplicador_seq_if
//  Brief    : Start/done request bus of the sequential multiplier.
//  Revision : 1.0 - initial release
// ============================================================================
interface multiplicador_seq_if
  import multiplicador_pkg::*;
#(
  parameter int N = c_default_n
);

  logic           start;
  logic           sgn;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic [2*N-1:0] p;
  logic           done;
  logic           busy;

  modport master (output start, sgn, a, b, input  p, done, busy);
  modport slave  (input  start, sgn, a, b, output p, done, busy);

endinterface
`default_nettype wire

// File: rtl/multiplicador_seq_uc.sv
`default_nettype none
// ============================================================================
//  Module   : multiplicador_seq_uc
//  Brief    : Control FSM of the shift-add multiplier; the skip input is tied
//             low by the top unless MULT_ZERO_SKIP_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module multiplicador_seq_uc
  import multiplicador_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic skip,
  input  logic q0,
  input  logic last,
  output logic load,
  output logic add,
  output logic shift,
  output logic clr_p,
  output logic done,
  output logic busy
);

  state_t r_state;
  state_t w_state_nx;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    load       = 1'b0;
    add        = 1'b0;
    shift      = 1'b0;
    clr_p      = 1'b0;
    done       = 1'b0;
    busy       = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (skip) begin
            clr_p      = 1'b1;
            w_state_nx = DONE;
          end else begin
            load       = 1'b1;
            w_state_nx = TEST;
          end
        end
      end
      TEST: begin
        busy       = 1'b1;
        w_state_nx = q0 ? ADD : SHIFT;
      end
      ADD: begin
        busy       = 1'b1;
        add        = 1'b1;
        w_state_nx = SHIFT;
      end
      SHIFT: begin
        busy       = 1'b1;
        shift      = 1'b1;
        w_state_nx = last ? DONE : TEST;
      end
      DONE: begin
        done = 1'b1;
        // A held request parks here so it cannot retrigger.
        if (!start) w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multiplicador_seq.sv
`default_nettype none
// ============================================================================
//  Module   : multiplicador_seq
//  Brief    : Parametrised sequential shift-add multiplier, signed/unsigned,
//             with optional zero-operand shortcut (MULT_ZERO_SKIP_EN).
//  Revision : 1.0 - initial release
// ============================================================================
module multiplicador_seq
  import multiplicador_pkg::*;
#(
  parameter int N = c_default_n
) (
  input  logic                clk,
  input  logic                rst,
  multiplicador_seq_if.slave  bus
);

  localparam int              c_cw       = $clog2(N + 1);
  localparam logic [c_cw-1:0] c_cnt_init = c_cw'(N);
  localparam logic [c_cw-1:0] c_cnt_one  = c_cw'(1);

  logic [N-1:0]     r_a, r_b, r_q;
  logic             r_c;
  logic [c_cw-1:0]  r_cnt;
  logic             r_neg;
  logic [2*N-1:0]   r_p;

  logic             w_load, w_add, w_shift, w_clr_p, w_skip, w_last;
  logic [c_mag_w-1:0] w_a_mag_full, w_b_mag_full;
  logic             w_unused_mag;
  logic [2*N-1:0]   w_prod;

  assign w_a_mag_full = magnitude(c_mag_w'(bus.a), bus.sgn & bus.a[N-1]);
  assign w_b_mag_full = magnitude(c_mag_w'(bus.b), bus.sgn & bus.b[N-1]);
  assign w_unused_mag = ^{w_a_mag_full, w_b_mag_full};

`ifdef MULT_ZERO_SKIP_EN
  assign w_skip = (bus.a == '0) || (bus.b == '0);
`else
  assign w_skip = 1'b0;
`endif

  assign w_last = (r_cnt == c_cnt_one);
  // {A,Q} after this cycle's right shift; C lands in A's MSB.
  assign w_prod = {r_c, r_a, r_q[N-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_q   <= '0;
      r_c   <= 1'b0;
      r_cnt <= '0;
      r_neg <= 1'b0;
      r_p   <= '0;
    end else if (w_load) begin
      r_b   <= w_b_mag_full[N-1:0];
      r_q   <= w_a_mag_full[N-1:0];
      r_a   <= '0;
      r_c   <= 1'b0;
      r_cnt <= c_cnt_init;
      r_neg <= bus.sgn & (bus.a[N-1] ^ bus.b[N-1]);
    end else if (w_add) begin
      {r_c, r_a} <= {1'b0, r_a} + {1'b0, r_b};
    end else if (w_shift) begin
      r_c   <= 1'b0;
      r_a   <= {r_c, r_a[N-1:1]};
      r_q   <= {r_a[0], r_q[N-1:1]};
      r_cnt <= r_cnt - c_cnt_one;
      if (w_last) r_p <= r_neg ? -w_prod : w_prod;
    end else if (w_clr_p) begin
      r_p <= '0;
    end
  end

  assign bus.p = r_p;

  multiplicador_seq_uc u_uc (
    .clk   (clk),
    .rst   (rst),
    .start (bus.start),
    .skip  (w_skip),
    .q0    (r_q[0]),
    .last  (w_last),
    .load  (w_load),
    .add   (w_add),
    .shift (w_shift),
    .clr_p (w_clr_p),
    .done  (bus.done),
    .busy  (bus.busy)
  );

endmodule
`default_nettype wire

// File: tb/tb_multiplicador_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multiplicador_seq
//  Brief    : Scoreboard bench for multiplicador_seq at N=8.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multiplicador_seq;

  localparam int N = 8;

  typedef struct {
    logic [2*N-1:0] p;
    int             lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_total = 0;
  int   n_bad   = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  multiplicador_seq_if #(.N(N)) bus ();

  multiplicador_seq #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic s, input logic [N-1:0] aa, input logic [N-1:0] bb);
    exp_t             e;
    logic [N-1:0]     mag;
    logic signed [2*N-1:0] sp;
    mag = (s && aa[N-1]) ? -aa : aa;
    if (s) begin
      sp  = $signed({{N{aa[N-1]}}, aa}) * $signed({{N{bb[N-1]}}, bb});
      e.p = sp;
    end else begin
      e.p = {{N{1'b0}}, aa} * {{N{1'b0}}, bb};
    end
    e.lat = 2 * N + $countones(mag);
`ifdef MULT_ZERO_SKIP_EN
    if (aa == '0 || bb == '0) e.lat = 0;
`endif
    return e;
  endfunction

  // Runs one request; latency counts edges after the sampling edge.
  task automatic do_op(input logic s, input logic [N-1:0] aa, input logic [N-1:0] bb,
                       input int hold, input bit pulse);
    exp_t e;
    int   n;
    sb.push_back(model(s, aa, bb));
    @(negedge clk);
    bus.start = 1'b1;
    bus.sgn   = s;
    bus.a     = aa;
    bus.b     = bb;
    @(posedge clk); #1;
    bus.a = N'($urandom);
    bus.b = N'($urandom);
    bus.sgn = 1'($urandom);
    n = 0;
    while (!bus.done && n < 200) begin
      chk("busy_run", {31'd0, bus.busy}, 32'd1);
      if (pulse && n == 2) bus.start = 1'b0;
      if (pulse && n == 4) bus.start = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    e = sb.pop_front();
    chk("latency", n, e.lat);
    chk("product", {16'd0, bus.p}, {16'd0, e.p});
    chk("busy_done", {31'd0, bus.busy}, 32'd0);
    repeat (hold) begin
      @(posedge clk); #1;
      chk("done_hold", {31'd0, bus.done}, 32'd1);
      chk("p_hold", {16'd0, bus.p}, {16'd0, e.p});
    end
    bus.start = 1'b0;
    @(posedge clk); #1;
    chk("done_drop", {31'd0, bus.done}, 32'd0);
    chk("busy_idle", {31'd0, bus.busy}, 32'd0);
    chk("p_keep", {16'd0, bus.p}, {16'd0, e.p});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.sgn   = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_p", {16'd0, bus.p}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    rst = 1'b0;

    do_op(1'b0, 8'd3,   8'd5,   5, 1'b0);
    do_op(1'b0, 8'hFF,  8'hFF,  1, 1'b0);
    do_op(1'b0, 8'hFD,  8'd5,   1, 1'b0);
    do_op(1'b1, 8'hFD,  8'd5,   1, 1'b0);
    do_op(1'b1, 8'h80,  8'h80,  1, 1'b0);
    do_op(1'b1, 8'h7F,  8'h80,  1, 1'b0);
    do_op(1'b0, 8'd0,   8'd77,  1, 1'b0);
    do_op(1'b1, 8'd9,   8'hF1,  2, 1'b1);

    // Abort an operation while it sits in ADD.
    @(negedge clk);
    bus.start = 1'b1;
    bus.sgn   = 1'b0;
    bus.a     = 8'hFF;
    bus.b     = 8'hFF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst       = 1'b1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    chk("abort_p", {16'd0, bus.p}, 32'd0);
    chk("abort_done", {31'd0, bus.done}, 32'd0);
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_idle", {31'd0, bus.busy}, 32'd0);
    do_op(1'b0, 8'd200, 8'd13, 1, 1'b0);

    for (int i = 0; i < 12; i++) begin
      do_op(1'($urandom), N'($urandom), N'($urandom), 1, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
